// File: rtl/change_dispenser.sv
// Change payout controller: pays an amount as dime-then-nickel ejects to a coin hopper.
// Optional ack timeout is built only when CHANGE_TIMEOUT_EN is defined.
module change_dispenser #(
    parameter int AMT_W       = 5,
    parameter int CNT_W       = 4,
    parameter int INIT_NICKEL = 4,
    parameter int INIT_DIME   = 4,
    parameter int GAP_CYCLES  = 2,
    parameter int ACK_TIMEOUT = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_valid,
    input  logic [AMT_W-1:0] req_amount,
    output logic             req_ready,
    output logic             eject_nickel,
    output logic             eject_dime,
    input  logic             hopper_ack,
    input  logic             load_nickel,
    input  logic             load_dime,
    output logic [CNT_W-1:0] nickel_count,
    output logic [CNT_W-1:0] dime_count,
    output logic [AMT_W-1:0] remaining,
    output logic             busy,
    output logic             pay_done,
    output logic             pay_short,
    output logic             pay_fault
);

    typedef enum logic [2:0] {
        IDLE,
        SELECT,
        EJECT_D,
        EJECT_N,
        GAP,
        FINISH
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [AMT_W-1:0] TEN      = AMT_W'(10);
    localparam logic [AMT_W-1:0] FIVE     = AMT_W'(5);
    localparam int               GAP_W    = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    state_t           state;
    logic [GAP_W-1:0] gap_cnt;
    logic             ack_d;
    logic             ack_n;
    logic [CNT_W-1:0] dime_next;
    logic [CNT_W-1:0] nickel_next;

`ifdef CHANGE_TIMEOUT_EN
    localparam int              TO_W    = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(ACK_TIMEOUT - 1);
    logic [TO_W-1:0] to_cnt;
    logic            timed_out;
    assign timed_out = (to_cnt == TO_LAST);
`else
    assign pay_fault = 1'b0;
`endif

    assign req_ready = (state == IDLE);
    assign busy      = (state != IDLE);
    assign ack_d     = (state == EJECT_D) && hopper_ack;
    assign ack_n     = (state == EJECT_N) && hopper_ack;

    // Saturating restock first, then the coin taken; at max a load+take yields max-1.
    always_comb begin
        dime_next = dime_count;
        if (load_dime && (dime_count != CNT_MAX)) begin
            dime_next = dime_count + 1'b1;
        end
        if (ack_d) begin
            dime_next = dime_next - 1'b1;
        end
    end

    always_comb begin
        nickel_next = nickel_count;
        if (load_nickel && (nickel_count != CNT_MAX)) begin
            nickel_next = nickel_count + 1'b1;
        end
        if (ack_n) begin
            nickel_next = nickel_next - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            gap_cnt      <= '0;
            eject_nickel <= 1'b0;
            eject_dime   <= 1'b0;
            pay_done     <= 1'b0;
            pay_short    <= 1'b0;
            remaining    <= '0;
            nickel_count <= CNT_W'(INIT_NICKEL);
            dime_count   <= CNT_W'(INIT_DIME);
`ifdef CHANGE_TIMEOUT_EN
            to_cnt       <= '0;
            pay_fault    <= 1'b0;
`endif
        end else begin
            nickel_count <= nickel_next;
            dime_count   <= dime_next;
            pay_done     <= 1'b0;
            pay_short    <= 1'b0;
`ifdef CHANGE_TIMEOUT_EN
            pay_fault    <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        remaining <= req_amount;
                        state     <= SELECT;
                    end
                end
                SELECT: begin
`ifdef CHANGE_TIMEOUT_EN
                    to_cnt <= '0;
`endif
                    if ((remaining >= TEN) && (dime_count != '0)) begin
                        eject_dime <= 1'b1;
                        state      <= EJECT_D;
                    end else if ((remaining >= FIVE) && (nickel_count != '0)) begin
                        eject_nickel <= 1'b1;
                        state        <= EJECT_N;
                    end else begin
                        pay_done  <= 1'b1;
                        pay_short <= (remaining != '0);
                        state     <= FINISH;
                    end
                end
                EJECT_D, EJECT_N: begin
                    if (hopper_ack) begin
                        eject_dime   <= 1'b0;
                        eject_nickel <= 1'b0;
                        remaining    <= remaining - ((state == EJECT_D) ? TEN : FIVE);
                        if (GAP_CYCLES == 0) begin
                            state <= SELECT;
                        end else begin
                            gap_cnt <= GAP_LAST;
                            state   <= GAP;
                        end
`ifdef CHANGE_TIMEOUT_EN
                    end else if (timed_out) begin
                        eject_dime   <= 1'b0;
                        eject_nickel <= 1'b0;
                        pay_done     <= 1'b1;
                        pay_short    <= 1'b1;
                        pay_fault    <= 1'b1;
                        state        <= FINISH;
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
`endif
                    end
                end
                GAP: begin
                    if (gap_cnt == '0) begin
                        state <= SELECT;
                    end else begin
                        gap_cnt <= gap_cnt - 1'b1;
                    end
                end
                FINISH: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_change_dispenser.sv
// Bench for change_dispenser: timeline reference model with per-cycle compare, directed and random payouts.
// Define CHANGE_TIMEOUT_EN for both files to exercise the ack timeout.
module tb_change_dispenser;

    localparam int AMT_W       = 5;
    localparam int CNT_W       = 4;
    localparam int INIT_NICKEL = 4;
    localparam int INIT_DIME   = 4;
    localparam int GAP_CYCLES  = 2;
    localparam int ACK_TIMEOUT = 64;
    localparam int CMAX        = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             req_valid = 1'b0;
    logic [AMT_W-1:0] req_amount = '0;
    logic             req_ready;
    logic             eject_nickel;
    logic             eject_dime;
    logic             hopper_ack = 1'b0;
    logic             load_nickel = 1'b0;
    logic             load_dime = 1'b0;
    logic [CNT_W-1:0] nickel_count;
    logic [CNT_W-1:0] dime_count;
    logic [AMT_W-1:0] remaining;
    logic             busy;
    logic             pay_done;
    logic             pay_short;
    logic             pay_fault;

    change_dispenser #(
        .AMT_W      (AMT_W),
        .CNT_W      (CNT_W),
        .INIT_NICKEL(INIT_NICKEL),
        .INIT_DIME  (INIT_DIME),
        .GAP_CYCLES (GAP_CYCLES),
        .ACK_TIMEOUT(ACK_TIMEOUT)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_amount  (req_amount),
        .req_ready   (req_ready),
        .eject_nickel(eject_nickel),
        .eject_dime  (eject_dime),
        .hopper_ack  (hopper_ack),
        .load_nickel (load_nickel),
        .load_dime   (load_dime),
        .nickel_count(nickel_count),
        .dime_count  (dime_count),
        .remaining   (remaining),
        .busy        (busy),
        .pay_done    (pay_done),
        .pay_short   (pay_short),
        .pay_fault   (pay_fault)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Expected observable state, updated just after each clock edge.
    int m_nc = INIT_NICKEL;
    int m_dc = INIT_DIME;
    int m_rem = 0;
    bit e_busy = 0, e_ed = 0, e_en = 0, e_done = 0, e_short = 0, e_fault = 0;
    bit restock_en = 0;
    int last_short, last_fault;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        check("req_ready", int'(req_ready), int'(!e_busy));
        check("busy", int'(busy), int'(e_busy));
        check("eject_dime", int'(eject_dime), int'(e_ed));
        check("eject_nickel", int'(eject_nickel), int'(e_en));
        check("pay_done", int'(pay_done), int'(e_done));
        check("pay_short", int'(pay_short), int'(e_short));
        check("pay_fault", int'(pay_fault), int'(e_fault));
        check("remaining", int'(remaining), m_rem);
        check("nickel_count", int'(nickel_count), m_nc);
        check("dime_count", int'(dime_count), m_dc);
        check("eject_exclusive", int'(eject_nickel & eject_dime), 0);
    end

    function automatic bit noise();
        return restock_en && ($urandom_range(0, 3) == 0);
    endfunction

    // One clock edge: apply ack, account inventory, then pick next restock pulses.
    task automatic tick(input bit ack, input bit dec_d, input bit dec_n);
        int sn, sd;
        hopper_ack = ack;
        @(posedge clk);
        #1;
        sn = m_nc + int'(load_nickel);
        sd = m_dc + int'(load_dime);
        m_nc = ((sn > CMAX) ? CMAX : sn) - int'(dec_n);
        m_dc = ((sd > CMAX) ? CMAX : sd) - int'(dec_d);
        hopper_ack = 1'b0;
        load_nickel = restock_en && ($urandom_range(0, 5) == 0);
        load_dime = restock_en && ($urandom_range(0, 5) == 0);
    endtask

    task automatic txn(input int amt, input int dly_lo, input int dly_hi, input bit hold,
                       input bit ld_d_on_ack, input bit ld_n_on_ack, input bit no_ack);
        int coin;
        int d;
        req_valid = 1'b1;
        req_amount = AMT_W'(amt);
        tick(noise(), 0, 0);
        m_rem = amt;
        e_busy = 1;
        req_valid = hold;
        req_amount = AMT_W'($urandom);
        forever begin
            if (m_rem >= 10 && m_dc > 0) coin = 10;
            else if (m_rem >= 5 && m_nc > 0) coin = 5;
            else coin = 0;
            if (coin == 0) break;
            tick(noise(), 0, 0);
            e_ed = (coin == 10);
            e_en = (coin == 5);
            if (no_ack) begin
                repeat (ACK_TIMEOUT) tick(0, 0, 0);
                e_ed = 0;
                e_en = 0;
                e_done = 1;
                e_short = 1;
                e_fault = 1;
                last_short = int'(pay_short);
                last_fault = int'(pay_fault);
                tick(noise(), 0, 0);
                e_done = 0;
                e_short = 0;
                e_fault = 0;
                e_busy = 0;
                req_valid = 1'b0;
                return;
            end
            d = $urandom_range(dly_lo, dly_hi);
            repeat (d) tick(0, 0, 0);
            if (ld_d_on_ack && coin == 10) load_dime = 1'b1;
            if (ld_n_on_ack && coin == 5) load_nickel = 1'b1;
            tick(1, coin == 10, coin == 5);
            e_ed = 0;
            e_en = 0;
            m_rem -= coin;
            repeat (GAP_CYCLES) tick(noise(), 0, 0);
        end
        tick(noise(), 0, 0);
        e_done = 1;
        e_short = (m_rem != 0);
        last_short = int'(pay_short);
        last_fault = int'(pay_fault);
        tick(noise(), 0, 0);
        e_done = 0;
        e_short = 0;
        e_busy = 0;
        req_valid = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    initial begin
        #23;
        reset = 1'b0;
        #1;
        check("reset_nickels", int'(nickel_count), 4);
        check("reset_dimes", int'(dime_count), 4);
        check("reset_remaining", int'(remaining), 0);
        check("reset_ready", int'(req_ready), 1);
        @(posedge clk);
        #1;

        // 15 cents: one dime, one nickel, exact.
        txn(15, 1, 1, 0, 0, 0, 0);
        check("tp15_dimes", int'(dime_count), 3);
        check("tp15_nickels", int'(nickel_count), 3);
        check("tp15_remaining", int'(remaining), 0);
        check("tp15_short", last_short, 0);

        // Drain dimes, then 20 cents with only three nickels.
        txn(30, 0, 2, 0, 0, 0, 0);
        check("drain_dimes", int'(dime_count), 0);
        txn(20, 0, 2, 0, 0, 0, 0);
        check("tp20_remaining", int'(remaining), 5);
        check("tp20_nickels", int'(nickel_count), 0);
        check("tp20_short", last_short, 1);

        repeat (4) begin
            load_dime = 1'b1;
            load_nickel = 1'b1;
            tick(0, 0, 0);
        end
        txn(7, 0, 2, 0, 0, 0, 0);
        check("tp7_remaining", int'(remaining), 2);
        check("tp7_nickels", int'(nickel_count), 3);
        check("tp7_short", last_short, 1);
        txn(0, 0, 0, 0, 0, 0, 0);
        check("tp0_remaining", int'(remaining), 0);
        check("tp0_short", last_short, 0);

        // Restock coinciding with a dime ack, then nickel saturation.
        txn(10, 0, 2, 0, 1, 0, 0);
        check("ld_on_ack_dimes", int'(dime_count), 4);
        repeat (13) begin
            load_nickel = 1'b1;
            tick(0, 0, 0);
        end
        check("nickel_saturated", int'(nickel_count), 15);
        txn(5, 0, 1, 0, 0, 1, 0);
        check("sat_load_and_take", int'(nickel_count), 14);

        // Request held valid through a payout, then serviced next.
        txn(25, 0, 2, 1, 0, 0, 0);
        txn(10, 0, 2, 0, 0, 0, 0);
        check("held_dimes", int'(dime_count), 1);
        check("held_nickels", int'(nickel_count), 13);

        // Reset while a dime is being ejected.
        req_valid = 1'b1;
        req_amount = AMT_W'(10);
        tick(0, 0, 0);
        m_rem = 10;
        e_busy = 1;
        req_valid = 1'b0;
        tick(0, 0, 0);
        e_ed = 1;
        #2;
        reset = 1'b1;
        m_nc = INIT_NICKEL;
        m_dc = INIT_DIME;
        m_rem = 0;
        e_busy = 0;
        e_ed = 0;
        #1;
        check("rst_eject_dime", int'(eject_dime), 0);
        check("rst_dimes", int'(dime_count), 4);
        check("rst_nickels", int'(nickel_count), 4);
        check("rst_pay_done", int'(pay_done), 0);
        @(posedge clk);
        #3;
        reset = 1'b0;
        @(posedge clk);
        #1;
        txn(15, 0, 2, 0, 0, 0, 0);
        check("post_rst_dimes", int'(dime_count), 3);
        check("post_rst_nickels", int'(nickel_count), 3);
        check("post_rst_short", last_short, 0);

`ifdef CHANGE_TIMEOUT_EN
        txn(10, 0, 0, 0, 0, 0, 1);
        check("to_remaining", int'(remaining), 10);
        check("to_dimes", int'(dime_count), 3);
        check("to_short", last_short, 1);
        check("to_fault", last_fault, 1);
`endif

        // Randomised payouts with restock and stray acks.
        restock_en = 1;
        for (int i = 0; i < 60; i++) begin
            txn($urandom_range(0, 31), 0, 3, $urandom_range(0, 3) == 0, 0, 0, 0);
            if (req_valid == 1'b0) begin
                repeat ($urandom_range(0, 2)) tick(noise(), 0, 0);
            end
        end
        restock_en = 0;
        tick(0, 0, 0);
        tick(0, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
